// File: rtl/toggle_debounce.sv
// -----------------------------------------------------------------------------
// toggle_debounce
// Debounces a raw, bouncing push-button and produces a one-cycle toggle strobe
// for a downstream T flip-flop, plus the debounced level.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable synchronized samples needed to accept
//                     a level change (2..65535)
//   REPEAT_CYCLES   : auto-repeat period while held (2..65535); only used when
//                     the macro TOGGLE_DEBOUNCE_REPEAT_EN is defined
//
// Ports:
//   clk      in   1  clock, rising edge
//   i_rst_n  in   1  asynchronous active-low reset
//   i_btn    in   1  raw asynchronous button level, active-high
//   i_en     in   1  strobe enable (gates o_t only)
//   o_t      out  1  one-cycle toggle strobe
//   o_level  out  1  debounced level
//   o_state  out  2  FSM state (00 IDLE, 01 PRESS_CHK, 10 HELD, 11 REL_CHK)
//
// Optional feature macro: TOGGLE_DEBOUNCE_REPEAT_EN (auto-repeat while held).
// -----------------------------------------------------------------------------
module toggle_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_btn,
    input  logic       i_en,
    output logic       o_t,
    output logic       o_level,
    output logic [1:0] o_state
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time guard on the legal parameter ranges.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_param
        $error("toggle_debounce: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRESS_CHK = 2'b01,
        HELD      = 2'b10,
        REL_CHK   = 2'b11
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_btn_s;
    logic          r_t;
    logic          r_level;
    logic          w_accept;
    logic          w_release;
    logic          w_rep_hit;

    // Two-flop synchronizer; only the second flop is used downstream.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s = r_sync2;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = PRESS_CHK;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_CHK: begin
                if (!w_btn_s) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            HELD: begin
                if (!w_btn_s) begin
                    w_state_nxt = REL_CHK;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            REL_CHK: begin
                if (w_btn_s) begin
                    // Bounce during release: back to HELD, no strobe.
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_release   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef TOGGLE_DEBOUNCE_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] r_rep;

    // Held outside HELD so every entry into HELD starts a fresh period.
    assign w_rep_hit = (r_state == HELD) && (r_rep == REP_LAST);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rep <= '0;
        end else if (r_state == HELD && !w_rep_hit) begin
            r_rep <= r_rep + RW'(1);
        end else begin
            r_rep <= '0;
        end
    end
`else
    assign w_rep_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_t     <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_t <= (w_accept | w_rep_hit) & i_en;
            if (w_accept) begin
                r_level <= 1'b1;
            end else if (w_release) begin
                r_level <= 1'b0;
            end
        end
    end

    assign o_t     = r_t;
    assign o_level = r_level;
    assign o_state = r_state;

endmodule

// File: tb/tb_toggle_debounce.sv
module tb_toggle_debounce;

    localparam int D = 4;
    localparam int R = 8;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_btn = 1'b0;
    logic       i_en = 1'b0;
    logic       o_t;
    logic       o_level;
    logic [1:0] o_state;

    always #5 clk = ~clk;

    toggle_debounce #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk    (clk),
        .i_rst_n(i_rst_n),
        .i_btn  (i_btn),
        .i_en   (i_en),
        .o_t    (o_t),
        .o_level(o_level),
        .o_state(o_state)
    );

    typedef struct {
        int   cyc;
        logic level;
        logic t;
    } ev_t;

    ev_t  exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   edge_cnt = 0;
    logic mon_prev = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: a change is accepted once D consecutive synchronized
    // samples disagree with the current level; synchronized sample at edge n
    // is the raw input seen at edge n-2.
    logic m_level;
    int   m_run;
    int   m_rep;
    logic m_pipe[$];

    function automatic void model_reset();
        m_level = 1'b0;
        m_run   = 0;
        m_rep   = 0;
        m_pipe  = {1'b0, 1'b0};
    endfunction

    function automatic void predict(input logic btn, input logic en, input int n);
        logic s;
        logic t;
        logic chg;
        logic held;
        s = m_pipe.pop_front();
        m_pipe.push_back(btn);
        held = m_level && (m_run == 0);
        t = 1'b0;
        chg = 1'b0;
`ifdef TOGGLE_DEBOUNCE_REPEAT_EN
        if (held) begin
            if (m_rep == R - 1) begin
                t = en;
                m_rep = 0;
            end else begin
                m_rep++;
            end
        end else begin
            m_rep = 0;
        end
`else
        if (held) m_rep = 0;
`endif
        if (s != m_level) begin
            m_run++;
            if (m_run == D) begin
                m_level = s;
                m_run = 0;
                chg = 1'b1;
                if (s) t = en;
            end
        end else begin
            m_run = 0;
        end
        if (chg || t) exp_q.push_back('{n, m_level, t});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Inputs change #1 after the falling edge and apply to the next rising edge.
    task automatic drive(input logic btn, input logic en);
        @(negedge clk);
        #1;
        i_btn = btn;
        i_en  = en;
        predict(btn, en, edge_cnt + 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("reset_async", {o_t, o_level, o_state}, 0);
        mon_prev = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("reset_held_state", o_state, 0);
        i_rst_n = 1'b1;
        predict(i_btn, i_en, edge_cnt + 1);
    endtask

    // Monitor: every DUT output event (o_t pulse or o_level change) is matched
    // against the oldest expected event.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
                ev = exp_q.pop_front();
                compared++;
                mismatched++;
                $display("FAIL missed_event: got nothing, expected level=%0d t=%0d at edge %0d",
                         ev.level, ev.t, ev.cyc);
            end
            if (i_rst_n && (o_t || o_level != mon_prev)) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_event: got level=%0d t=%0d at edge %0d, expected none",
                             o_level, o_t, edge_cnt);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.cyc != edge_cnt || ev.level != o_level || ev.t != o_t) begin
                        mismatched++;
                        $display("FAIL event: got edge=%0d level=%0d t=%0d, expected edge=%0d level=%0d t=%0d",
                                 edge_cnt, o_level, o_t, ev.cyc, ev.level, ev.t);
                    end
                end
            end
            mon_prev = o_level;
        end
    end

    initial begin
        int e0;
        logic lvl;
        int len;

        model_reset();
        #2;
        check("reset_state", {o_t, o_level, o_state}, 0);
        @(negedge clk);
        #1;
        i_rst_n = 1'b1;
        predict(i_btn, i_en, edge_cnt + 1);
        repeat (4) drive(1'b0, 1'b1);

        // Latency: first edge sampling 1 is e0; level and strobe after e0+D+1.
        drive(1'b1, 1'b1);
        e0 = edge_cnt + 1;
        for (int i = 0; i < D + 4; i++) begin
            drive(1'b1, 1'b1);
            if (edge_cnt == e0 + D) check("lat_level_before", o_level, 0);
            if (edge_cnt == e0 + D + 1) check("lat_accept", {o_t, o_level, o_state}, 4'b1110);
            if (edge_cnt == e0 + D + 2) check("lat_strobe_one_cycle", o_t, 0);
        end

        // Release bounce: two high samples during REL_CHK return to HELD.
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b1);
        check("bounce_held", {o_level, o_state}, 3'b110);
        repeat (D + 4) drive(1'b0, 1'b1);
        check("release_idle", {o_t, o_level, o_state}, 0);

        // Glitch of D-1 samples.
        repeat (D - 1) drive(1'b1, 1'b1);
        repeat (D + 3) drive(1'b0, 1'b1);
        check("glitch_idle", {o_t, o_level, o_state}, 0);

        // Press with strobe disabled.
        repeat (D + 4) drive(1'b1, 1'b0);
        check("en0_level", {o_t, o_level, o_state}, 4'b0110);
        repeat (D + 4) drive(1'b0, 1'b1);

        // Reset in PRESS_CHK with count=3, button kept held.
        repeat (5) drive(1'b1, 1'b1);
        check("press_chk_state", o_state, 1);
        do_reset();
        repeat (D + 5) drive(1'b1, 1'b1);
        check("post_reset_accept", {o_level, o_state}, 3'b110);
        repeat (D + 4) drive(1'b0, 1'b1);

        // Randomized segments with occasional resets.
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 29) == 0) do_reset();
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            for (int k = 0; k < len; k++) drive(lvl, $urandom_range(0, 3) != 0);
        end

        repeat (D + 6) drive(1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
